// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush and bubble/stall counters
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               clr_cnt_i,
    input  logic               valid_i,
    input  logic [1:0]         WB_i,
    input  logic [2:0]         EX_i,
    input  logic [1:0]         MEM_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic [DATA_W-1:0]  rs_data_i,
    input  logic [DATA_W-1:0]  rt_data_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [RADDR_W-1:0] rs_addr_i,
    input  logic [RADDR_W-1:0] rt_addr_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    output logic [1:0]         WB_o,
    output logic [2:0]         EX_o,
    output logic [1:0]         MEM_o,
    output logic [DATA_W-1:0]  pc_o,
    output logic [DATA_W-1:0]  rs_data_o,
    output logic [DATA_W-1:0]  rt_data_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [RADDR_W-1:0] rs_addr_o,
    output logic [RADDR_W-1:0] rt_addr_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               valid_o,
    output logic               mem_read_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage state: reset > flush (bubble, operands held) > stall (hold) > load
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            WB_o      <= '0;
            EX_o      <= '0;
            MEM_o     <= '0;
            pc_o      <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_addr_o <= '0;
            rt_addr_o <= '0;
            rd_addr_o <= '0;
            valid_o   <= 1'b0;
        end else if (flush_i) begin
            // Zeroed addresses keep a bubble from ever matching a forwarding source
            WB_o      <= '0;
            EX_o      <= '0;
            MEM_o     <= '0;
            rs_addr_o <= '0;
            rt_addr_o <= '0;
            rd_addr_o <= '0;
            valid_o   <= 1'b0;
        end else if (!stall_i) begin
            WB_o      <= WB_i;
            EX_o      <= EX_i;
            MEM_o     <= MEM_i;
            pc_o      <= pc_i;
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_addr_o <= rs_addr_i;
            rt_addr_o <= rt_addr_i;
            rd_addr_o <= rd_addr_i;
            valid_o   <= valid_i;
        end
    end

    // Saturating counters; a stall+flush cycle counts only as a bubble, clear wins over increment
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_cnt_i) begin
            bubble_cnt_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            if (flush_i && (bubble_cnt_o != CNT_MAX)) begin
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            end
            if (stall_i && !flush_i && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

    assign mem_read_o = MEM_o[1] & valid_o;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, clr_cnt, valid;
    logic [1:0]  wb_in, mem_in;
    logic [2:0]  ex_in;
    logic [31:0] pc_in, rs_data_in, rt_data_in, imm_in;
    logic [4:0]  rs_addr_in, rt_addr_in, rd_addr_in;

    logic [1:0]  wb_out, mem_out;
    logic [2:0]  ex_out;
    logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out;
    logic [4:0]  rs_addr_out, rt_addr_out, rd_addr_out;
    logic        valid_out, mem_read_out;
    logic [15:0] bubble_cnt, stall_cnt;

    logic [1:0]  wb4, mem4;
    logic [2:0]  ex4;
    logic [31:0] pc4, rsd4, rtd4, imm4;
    logic [4:0]  rsa4, rta4, rda4;
    logic        valid4, mem_read4;
    logic [3:0]  bubble_cnt4, stall_cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .clr_cnt_i(clr_cnt),
        .valid_i(valid), .WB_i(wb_in), .EX_i(ex_in), .MEM_i(mem_in), .pc_i(pc_in),
        .rs_data_i(rs_data_in), .rt_data_i(rt_data_in), .imm_i(imm_in),
        .rs_addr_i(rs_addr_in), .rt_addr_i(rt_addr_in), .rd_addr_i(rd_addr_in),
        .WB_o(wb_out), .EX_o(ex_out), .MEM_o(mem_out), .pc_o(pc_out),
        .rs_data_o(rs_data_out), .rt_data_o(rt_data_out), .imm_o(imm_out),
        .rs_addr_o(rs_addr_out), .rt_addr_o(rt_addr_out), .rd_addr_o(rd_addr_out),
        .valid_o(valid_out), .mem_read_o(mem_read_out),
        .bubble_cnt_o(bubble_cnt), .stall_cnt_o(stall_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .clr_cnt_i(clr_cnt),
        .valid_i(valid), .WB_i(wb_in), .EX_i(ex_in), .MEM_i(mem_in), .pc_i(pc_in),
        .rs_data_i(rs_data_in), .rt_data_i(rt_data_in), .imm_i(imm_in),
        .rs_addr_i(rs_addr_in), .rt_addr_i(rt_addr_in), .rd_addr_i(rd_addr_in),
        .WB_o(wb4), .EX_o(ex4), .MEM_o(mem4), .pc_o(pc4),
        .rs_data_o(rsd4), .rt_data_o(rtd4), .imm_o(imm4),
        .rs_addr_o(rsa4), .rt_addr_o(rta4), .rd_addr_o(rda4),
        .valid_o(valid4), .mem_read_o(mem_read4),
        .bubble_cnt_o(bubble_cnt4), .stall_cnt_o(stall_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_stage(input string tag, input logic [1:0] wb, input logic [2:0] ex,
                               input logic [1:0] mem, input logic [31:0] pc, input logic [31:0] rsd,
                               input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rsa,
                               input logic [4:0] rta, input logic [4:0] rda, input logic v,
                               input logic mr);
        check({tag, ".wb"},      64'(wb_out),       64'(wb));
        check({tag, ".ex"},      64'(ex_out),       64'(ex));
        check({tag, ".mem"},     64'(mem_out),      64'(mem));
        check({tag, ".pc"},      64'(pc_out),       64'(pc));
        check({tag, ".rs_data"}, 64'(rs_data_out),  64'(rsd));
        check({tag, ".rt_data"}, 64'(rt_data_out),  64'(rtd));
        check({tag, ".imm"},     64'(imm_out),      64'(imm));
        check({tag, ".rs_addr"}, 64'(rs_addr_out),  64'(rsa));
        check({tag, ".rt_addr"}, 64'(rt_addr_out),  64'(rta));
        check({tag, ".rd_addr"}, 64'(rd_addr_out),  64'(rda));
        check({tag, ".valid"},   64'(valid_out),    64'(v));
        check({tag, ".mem_read"},64'(mem_read_out), 64'(mr));
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] ex, input logic [1:0] mem,
                         input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic [4:0] rsa, input logic [4:0] rta,
                         input logic [4:0] rda, input logic v);
        wb_in = wb; ex_in = ex; mem_in = mem; pc_in = pc;
        rs_data_in = rsd; rt_data_in = rtd; imm_in = imm;
        rs_addr_in = rsa; rt_addr_in = rta; rd_addr_in = rda; valid = v;
    endtask

    initial begin
        // Reset with every input at all-ones for two edges
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1; clr_cnt = 1'b1;
        drive('1, '1, '1, '1, '1, '1, '1, '1, '1, '1, 1'b1);
        step(2);
        check_stage("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.bubble_cnt", 64'(bubble_cnt), 0);
        check("reset.stall_cnt",  64'(stall_cnt),  0);
        check("reset.valid4",     64'(valid4),     0);

        // Plain load
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        drive(2'b10, 3'b101, 2'b10, 32'h100, 32'h1234, 32'h5678, 32'hffff_fff0,
              5'd3, 5'd4, 5'd9, 1'b1);
        step(1);
        check_stage("load", 2'b10, 3'b101, 2'b10, 32'h100, 32'h1234, 32'h5678, 32'hffff_fff0,
                    5'd3, 5'd4, 5'd9, 1'b1, 1'b1);

        // Stall three cycles while presenting different inputs
        stall = 1'b1;
        drive(2'b01, 3'b010, 2'b01, 32'h200, 32'hdead, 32'hbeef, 32'h7, 5'd10, 5'd11, 5'd7, 1'b0);
        step(3);
        check_stage("stall", 2'b10, 3'b101, 2'b10, 32'h100, 32'h1234, 32'h5678, 32'hffff_fff0,
                    5'd3, 5'd4, 5'd9, 1'b1, 1'b1);
        check("stall.stall_cnt",  64'(stall_cnt),  3);
        check("stall.bubble_cnt", 64'(bubble_cnt), 0);
        check("stall.stall_cnt4", 64'(stall_cnt4), 3);

        // Flush together with stall: bubble only, operands held
        flush = 1'b1;
        step(1);
        check_stage("flush_stall", 0, 0, 0, 32'h100, 32'h1234, 32'h5678, 32'hffff_fff0,
                    0, 0, 0, 0, 0);
        check("flush_stall.bubble_cnt", 64'(bubble_cnt), 1);
        check("flush_stall.stall_cnt",  64'(stall_cnt),  3);

        // Load of a load/store with valid_i=0: mem_read_o must stay low
        flush = 1'b0; stall = 1'b0;
        drive(2'b11, 3'b011, 2'b11, 32'h300, 32'ha5a5, 32'h5a5a, 32'h1, 5'd1, 5'd2, 5'd31, 1'b0);
        step(1);
        check_stage("load_invalid", 2'b11, 3'b011, 2'b11, 32'h300, 32'ha5a5, 32'h5a5a, 32'h1,
                    5'd1, 5'd2, 5'd31, 1'b0, 1'b0);

        // Twenty flush cycles: 4-bit counter saturates, 16-bit one keeps counting
        flush = 1'b1;
        step(20);
        check("sat.bubble_cnt4", 64'(bubble_cnt4), 15);
        check("sat.bubble_cnt",  64'(bubble_cnt),  21);
        check("sat.stall_cnt4",  64'(stall_cnt4),  3);
        check("sat.rs_data",     64'(rs_data_out), 32'ha5a5);

        // Clear beats a same-cycle flush increment
        clr_cnt = 1'b1;
        step(1);
        check("clr.bubble_cnt4", 64'(bubble_cnt4), 0);
        check("clr.bubble_cnt",  64'(bubble_cnt),  0);
        check("clr.stall_cnt",   64'(stall_cnt),   0);
        clr_cnt = 1'b0; flush = 1'b0;

        // Build up some state, then reset while stalling
        drive(2'b10, 3'b001, 2'b10, 32'h400, 32'h11, 32'h22, 32'h33, 5'd5, 5'd6, 5'd8, 1'b1);
        step(1);
        stall = 1'b1;
        step(2);
        check("pre_rst.stall_cnt", 64'(stall_cnt), 2);
        rst_n = 1'b0;
        step(1);
        check_stage("rst_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_stall.stall_cnt", 64'(stall_cnt), 0);

        // Normal load resumes on the next edge
        rst_n = 1'b1; stall = 1'b0;
        drive(2'b01, 3'b110, 2'b10, 32'h500, 32'hcafe, 32'hf00d, 32'h44, 5'd12, 5'd13, 5'd14, 1'b1);
        step(1);
        check_stage("resume", 2'b01, 3'b110, 2'b10, 32'h500, 32'hcafe, 32'hf00d, 32'h44,
                    5'd12, 5'd13, 5'd14, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
